// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_pkg
// Purpose  : Shared constants and types for the DMA store-path arbiter.
//            Defines default channel count, data/address widths, ID FIFO
//            depth and the 1-bit arbiter state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dma_pkg;

  localparam int DMA_N_CH    = 4;
  localparam int DMA_DATA_WD = 32;
  localparam int DMA_ADDR_WD = 32;
  localparam int DMA_OUTST   = 2;

  typedef enum logic [0:0] {
    ST_ARB_IDLE = 1'b0,
    ST_ARB_BUSY = 1'b1
  } arb_state_e;

endpackage : dma_pkg
`default_nettype wire

// File: rtl/dma_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dma_id_fifo
// Purpose  : In-order FIFO of channel IDs for granted-but-unanswered stores.
// Ports    : clk_i/rstn_i  - clock, async active-low reset
//            push_i/push_data_i - enqueue an ID
//            pop_i         - dequeue the head ID
//            full_o/empty_o - occupancy flags
//            head_o        - oldest ID
//            count_o       - current number of entries
// Revision : 1.0 - initial release
// ============================================================================
module dma_id_fifo #(
  parameter int DEPTH  = 2,
  parameter int WIDTH  = 2,
  parameter int CNT_WD = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [WIDTH-1:0]  head_o,
  output logic [CNT_WD-1:0] count_o
);

  localparam int PTR_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [PTR_WD-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WD-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WD-1:0] count_q, count_d;
  logic              push_en, pop_en;

  // Pointer increment that wraps correctly for non-power-of-two depths.
  function automatic logic [PTR_WD-1:0] ptr_inc(input logic [PTR_WD-1:0] p);
    ptr_inc = (p == PTR_WD'(DEPTH - 1)) ? '0 : p + PTR_WD'(1);
  endfunction

  assign full_o  = (count_q == CNT_WD'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_en) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_WD'(1);
      2'b01:   count_d = count_q - CNT_WD'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : dma_id_fifo
`default_nettype wire

// File: rtl/dma_st_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dma_st_arbiter
// Purpose  : Round-robin arbiter sharing the core store bus among N_CH DMA
//            channels. Holds the winning request stable until the bus grants
//            it, routes the grant back, and routes in-order responses to the
//            issuing channel via an ID FIFO.
// Ports    : clk_i/rstn_i        - clock, async active-low reset
//            ch_st_*_i / *_o     - packed per-channel store request side
//            core_st_*_i / *_o   - single core store bus port
//            resp_err_o          - sticky: response seen with no outstanding
// Revision : 1.0 - initial release
// ============================================================================
module dma_st_arbiter
  import dma_pkg::*;
#(
  parameter int N_CH    = DMA_N_CH,
  parameter int DATA_WD = DMA_DATA_WD,
  parameter int ADDR_WD = DMA_ADDR_WD,
  parameter int BE_WD   = DATA_WD / 8,
  parameter int OUTST   = DMA_OUTST
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [N_CH-1:0]         ch_st_req_i,
  input  logic [N_CH-1:0]         ch_st_we_i,
  input  logic [N_CH*BE_WD-1:0]   ch_st_be_i,
  input  logic [N_CH*ADDR_WD-1:0] ch_st_addr_i,
  input  logic [N_CH*DATA_WD-1:0] ch_st_wdata_i,
  output logic [N_CH-1:0]         ch_st_gnt_o,
  output logic [DATA_WD-1:0]      ch_st_rdata_o,
  output logic [N_CH-1:0]         ch_st_rvalid_o,
  output logic                    core_st_req_o,
  input  logic                    core_st_gnt_i,
  output logic                    core_st_we_o,
  output logic [BE_WD-1:0]        core_st_be_o,
  output logic [ADDR_WD-1:0]      core_st_addr_o,
  output logic [DATA_WD-1:0]      core_st_wdata_o,
  input  logic [DATA_WD-1:0]      core_st_rdata_i,
  input  logic                    core_st_rvalid_i,
  output logic                    resp_err_o
);

  localparam int ID_WD  = $clog2(N_CH);
  localparam int CNT_WD = $clog2(OUTST + 1);

  arb_state_e        state_q, state_d;
  logic [ID_WD-1:0]  sel_q, sel_d;
  logic [ID_WD-1:0]  ptr_q, ptr_d;
  logic              resp_err_q, resp_err_d;

  logic              fifo_full, fifo_empty;
  logic [ID_WD-1:0]  fifo_head;
  logic [CNT_WD-1:0] fifo_count;
  logic [CNT_WD:0]   count_nxt;

  logic              busy, fire, pop, room;
  logic [N_CH-1:0]   sel_onehot, elig;
  logic [ID_WD-1:0]  pick;

  // First set bit of req scanning ptr, ptr+1, ... ; the index wraps
  // naturally because N_CH is a power of two. Scanning from the far end
  // lets the nearest eligible channel overwrite the result last.
  function automatic logic [ID_WD-1:0] rr_pick(input logic [N_CH-1:0]  req,
                                               input logic [ID_WD-1:0] ptr);
    logic [ID_WD-1:0] idx;
    rr_pick = ptr;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = ptr + ID_WD'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  assign busy       = (state_q == ST_ARB_BUSY);
  assign fire       = busy & core_st_gnt_i;
  assign pop        = core_st_rvalid_i & ~fifo_empty;
  assign sel_onehot = N_CH'(1) << sel_q;

  // The just-granted channel still shows req in its grant cycle; hide it so
  // it cannot be picked again before it drops req.
  assign elig = ch_st_req_i & ~(fire ? sel_onehot : '0);

  // The pointer moves past the winner on a grant; the follow-on pick uses
  // the moved pointer so back-to-back grants stay fair.
  assign ptr_d = fire ? sel_q + ID_WD'(1) : ptr_q;
  assign pick  = rr_pick(elig, ptr_d);

  // Room is judged on the occupancy after this cycle's push and pop.
  assign count_nxt = {1'b0, fifo_count} + {{CNT_WD{1'b0}}, fire}
                   - {{CNT_WD{1'b0}}, pop};
  assign room      = fire ? (count_nxt < (CNT_WD + 1)'(OUTST))
                          : (~fifo_full | pop);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    resp_err_d = resp_err_q | (core_st_rvalid_i & fifo_empty);
    case (state_q)
      ST_ARB_IDLE: begin
        if ((|elig) && room) begin
          sel_d   = pick;
          state_d = ST_ARB_BUSY;
        end
      end
      ST_ARB_BUSY: begin
        // sel is frozen until the bus accepts the request.
        if (fire) begin
          if ((|elig) && room) sel_d   = pick;
          else                 state_d = ST_ARB_IDLE;
        end
      end
      default: state_d = ST_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_ARB_IDLE;
      sel_q      <= '0;
      ptr_q      <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      resp_err_q <= resp_err_d;
    end
  end

  dma_id_fifo #(
    .DEPTH  (OUTST),
    .WIDTH  (ID_WD),
    .CNT_WD (CNT_WD)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .push_i      (fire),
    .push_data_i (sel_q),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign core_st_req_o   = busy;
  assign core_st_we_o    = ch_st_we_i[sel_q];
  assign core_st_be_o    = ch_st_be_i[int'(sel_q) * BE_WD +: BE_WD];
  assign core_st_addr_o  = ch_st_addr_i[int'(sel_q) * ADDR_WD +: ADDR_WD];
  assign core_st_wdata_o = ch_st_wdata_i[int'(sel_q) * DATA_WD +: DATA_WD];

  assign ch_st_gnt_o    = fire ? sel_onehot : '0;
  assign ch_st_rvalid_o = pop ? (N_CH'(1) << fifo_head) : '0;
  assign ch_st_rdata_o  = core_st_rdata_i;
  assign resp_err_o     = resp_err_q;

endmodule : dma_st_arbiter
`default_nettype wire
